mac_rx_flit_framer: RTL and testbench

Parametrised receive-side bridge between the 10G MAC receive stream and a router local input port. Each MAC word is tagged header, body or tail as it is written. The packet length is taken from the header word, not inferred from gaps. Tagged words are buffered in a configurable-depth FIFO and presented as router flits under a strict val/ack handshake that never stalls between back-to-back packets; framing, overflow and CRC errors are reported through counters and flags.

---
 rtl/mac_rx_flit_framer.sv | 166 ++++++++++++++++
 tb/tb_mac_rx_flit_framer.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_rx_flit_framer.sv
// Receive-side bridge: tags MAC words head/body/tail from the header length field,
// buffers them in a FIFO and presents them to the router as flits.
module mac_rx_flit_framer #(
  parameter int MAC_W      = 64,
  parameter int VLD_W      = 4,
  parameter int FLIT_W     = MAC_W + VLD_W + 2,
  parameter int FIFO_DEPTH = 16,
  parameter int AFULL_GAP  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [MAC_W-1:0]  mac_data,
  input  logic [VLD_W-1:0]  mac_valid,
  input  logic              mac_done,
  input  logic              mac_crc_err,
  output logic [FLIT_W-1:0] flit_data,
  output logic              flit_val,
  input  logic              flit_ack,
  output logic              fifo_afull,
  output logic              overflow,
  output logic              len_err,
  output logic [15:0]       drop_cnt,
  output logic [15:0]       crc_cnt,
  output logic [1:0]        dbg_state
);
  // flit_val/flit_ack: a flit transfers on a cycle where both are high; while
  // flit_val is high and flit_ack is low, flit_data and flit_val hold steady.

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [1:0] TAG_HEAD = 2'b10;
  localparam logic [1:0] TAG_BODY = 2'b00;
  localparam logic [1:0] TAG_TAIL = 2'b01;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BODY    = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [14:0] remain, remain_nxt;
  logic        present;
  logic [13:0] hdr_len;
  logic [4:0]  hdr_type;
  logic [14:0] pkt_len;
  logic [1:0]  tag;
  logic        wr_req, discard_word, len_err_nxt;

  assign present  = |mac_valid;
  assign hdr_len  = mac_data[61:48];
  assign hdr_type = mac_data[47:43];
  // Types 0 and 3 are fixed four-word packets; others carry a payload length.
  assign pkt_len  = (hdr_type == 5'd0 || hdr_type == 5'd3) ? 15'd4
                                                           : ({1'b0, hdr_len} + 15'd5);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      remain <= '0;
    end else begin
      state  <= state_nxt;
      remain <= remain_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    remain_nxt   = remain;
    tag          = TAG_BODY;
    wr_req       = 1'b0;
    discard_word = 1'b0;
    len_err_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (present) begin
          tag        = TAG_HEAD;
          wr_req     = 1'b1;
          remain_nxt = pkt_len - 15'd1;
          state_nxt  = BODY;
        end
      end
      BODY: begin
        if (present) begin
          wr_req     = 1'b1;
          remain_nxt = remain - 15'd1;
          if (remain == 15'd1) begin
            tag         = TAG_TAIL;
            state_nxt   = mac_done ? IDLE : DISCARD;
            len_err_nxt = !mac_done;
          end else if (mac_done) begin
            tag         = TAG_TAIL;
            len_err_nxt = 1'b1;
            state_nxt   = IDLE;
          end
        end
      end
      DISCARD: begin
        if (present) begin
          discard_word = 1'b1;
          if (mac_done) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign dbg_state = state;

  logic [FLIT_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count, count_nxt;
  logic              full, fifo_wr, fifo_rd, lost_word;

  assign full      = (count == CW'(FIFO_DEPTH));
  assign fifo_wr   = wr_req && !full;
  assign lost_word = wr_req && full;
  // Output register is refilled whenever it is empty or being consumed.
  assign fifo_rd   = (count != '0) && (!flit_val || flit_ack);
  assign count_nxt = count + {{AW{1'b0}}, fifo_wr} - {{AW{1'b0}}, fifo_rd};

  always_ff @(posedge clk) begin
    if (fifo_wr) mem[wr_ptr] <= {tag, mac_data, mac_valid};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      fifo_afull <= 1'b0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
      count      <= count_nxt;
      fifo_afull <= (CW'(FIFO_DEPTH) - count_nxt) <= CW'(AFULL_GAP);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flit_data <= '0;
      flit_val  <= 1'b0;
    end else if (fifo_rd) begin
      flit_data <= mem[rd_ptr];
      flit_val  <= 1'b1;
    end else if (flit_ack) begin
      flit_val  <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      len_err  <= 1'b0;
      drop_cnt <= '0;
      crc_cnt  <= '0;
    end else begin
      len_err <= len_err_nxt;
      if (lost_word) overflow <= 1'b1;
      if ((discard_word || lost_word) && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      if (present && mac_done && mac_crc_err && crc_cnt != 16'hFFFF) crc_cnt <= crc_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_mac_rx_flit_framer.sv
// Bench for mac_rx_flit_framer: frame-level reference model with per-cycle
// comparison, plus directed frames with hand-computed tag sequences and counts.
module tb_mac_rx_flit_framer;
  localparam int MAC_W      = 64;
  localparam int VLD_W      = 4;
  localparam int FLIT_W     = MAC_W + VLD_W + 2;
  localparam int FIFO_DEPTH = 16;
  localparam int AFULL_GAP  = 2;

  logic              clk;
  logic              rst;
  logic [MAC_W-1:0]  mac_data;
  logic [VLD_W-1:0]  mac_valid;
  logic              mac_done;
  logic              mac_crc_err;
  logic [FLIT_W-1:0] flit_data;
  logic              flit_val;
  logic              flit_ack;
  logic              fifo_afull;
  logic              overflow;
  logic              len_err;
  logic [15:0]       drop_cnt;
  logic [15:0]       crc_cnt;
  logic [1:0]        dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ack_mode = 0;
  bit started  = 0;

  logic [FLIT_W-1:0] exp_q[$];
  logic [FLIT_W-1:0] m_out;
  bit m_val, m_afull, m_ovf, m_lenerr, m_active;
  int m_drop, m_crc, m_idx, m_len;

  logic [1:0] rx_tags[$];
  int  lenerr_seen, val_cyc, afull_cyc, t0;
  bit  arm_val, arm_afull;

  mac_rx_flit_framer #(
    .MAC_W(MAC_W), .VLD_W(VLD_W), .FLIT_W(FLIT_W),
    .FIFO_DEPTH(FIFO_DEPTH), .AFULL_GAP(AFULL_GAP)
  ) dut (
    .clk(clk), .rst(rst), .mac_data(mac_data), .mac_valid(mac_valid),
    .mac_done(mac_done), .mac_crc_err(mac_crc_err), .flit_data(flit_data),
    .flit_val(flit_val), .flit_ack(flit_ack), .fifo_afull(fifo_afull),
    .overflow(overflow), .len_err(len_err), .drop_cnt(drop_cnt),
    .crc_cnt(crc_cnt), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // ack pattern: 0 = held low, 1 = held high, 2 = toggling
  initial begin
    flit_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ack_mode == 0)      flit_ack = 1'b0;
      else if (ack_mode == 1) flit_ack = 1'b1;
      else                    flit_ack = ~flit_ack;
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference model: packet rules by word index, FIFO as a bounded queue
  always @(posedge clk) begin : model
    int old_size;
    bit wr;
    logic [1:0] tag;
    int typ, len;
    if (rst) begin
      exp_q.delete();
      m_out = '0; m_val = 0; m_afull = 0; m_ovf = 0; m_lenerr = 0; m_active = 0;
      m_drop = 0; m_crc = 0; m_idx = 0; m_len = 0;
      started = 1;
    end else begin
      wr = 0; tag = 2'b00; m_lenerr = 0;
      if (mac_valid != '0) begin
        if (mac_done && mac_crc_err && m_crc < 65535) m_crc++;
        if (!m_active) begin
          typ = int'(mac_data[47:43]);
          len = int'(mac_data[61:48]);
          m_len = (typ == 0 || typ == 3) ? 4 : len + 5;
          m_idx = 1; m_active = 1; wr = 1; tag = 2'b10;
        end else begin
          m_idx++;
          if (m_idx < m_len) begin
            wr = 1;
            if (mac_done) begin tag = 2'b01; m_lenerr = 1; m_active = 0; end
          end else if (m_idx == m_len) begin
            wr = 1; tag = 2'b01;
            if (mac_done) m_active = 0;
            else m_lenerr = 1;
          end else begin
            if (m_drop < 65535) m_drop++;
            if (mac_done) m_active = 0;
          end
        end
      end
      old_size = exp_q.size();
      if (wr) begin
        if (old_size < FIFO_DEPTH) exp_q.push_back({tag, mac_data, mac_valid});
        else begin m_ovf = 1; if (m_drop < 65535) m_drop++; end
      end
      if (old_size > 0 && (!m_val || flit_ack)) begin
        m_out = exp_q.pop_front();
        m_val = 1;
      end else if (flit_ack) begin
        m_val = 0;
      end
      m_afull = (FIFO_DEPTH - exp_q.size()) <= AFULL_GAP;
    end
  end

  // scoreboard compare, away from the active edge
  always @(negedge clk) begin
    if (started) begin
      check("flit_val", flit_val, m_val);
      if (m_val) check("flit_data", flit_data, m_out);
      check("fifo_afull", fifo_afull, m_afull);
      check("overflow", overflow, m_ovf);
      check("len_err", len_err, m_lenerr);
      check("drop_cnt", drop_cnt, m_drop);
      check("crc_cnt", crc_cnt, m_crc);
      if (flit_val && flit_ack) rx_tags.push_back(flit_data[FLIT_W-1 -: 2]);
      if (len_err) lenerr_seen++;
      if (arm_val && flit_val) begin val_cyc = cyc; arm_val = 0; end
      if (arm_afull && fifo_afull) begin afull_cyc = cyc; arm_afull = 0; end
    end
  end

  // driver tasks
  task automatic drive(input logic [MAC_W-1:0] d, input logic [VLD_W-1:0] v,
                       input bit done, input bit crc);
    @(posedge clk);
    #1;
    mac_data = d; mac_valid = v; mac_done = done; mac_crc_err = crc;
  endtask

  task automatic send_hdr(input int typ, input int len);
    logic [MAC_W-1:0] d;
    d = {$urandom, $urandom};
    d[61:48] = len[13:0];
    d[47:43] = typ[4:0];
    drive(d, VLD_W'($urandom_range(1, 15)), 1'b0, 1'b0);
  endtask

  task automatic send_word(input bit done, input bit crc);
    drive({$urandom, $urandom}, VLD_W'($urandom_range(1, 15)), done, crc);
  endtask

  task automatic gap(input bit done);
    drive({$urandom, $urandom}, '0, done, done);
  endtask

  task automatic drain();
    int n;
    n = 0;
    ack_mode = 1;
    while ((exp_q.size() != 0 || m_val) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", (exp_q.size() == 0 && !m_val), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_tags(input string name, input int n, input logic [63:0] pk);
    check({name, "_count"}, rx_tags.size(), n);
    for (int i = 0; i < n && i < rx_tags.size(); i++)
      check({name, "_tag"}, rx_tags[i], pk[2*i +: 2]);
  endtask

  task automatic start_case();
    rx_tags.delete();
    lenerr_seen = 0;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst = 1'b1; mac_valid = '0; mac_done = 1'b0; mac_crc_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; mac_data = '0; mac_valid = '0; mac_done = 1'b0; mac_crc_err = 1'b0;
    arm_val = 0; arm_afull = 0; lenerr_seen = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_flit_val", flit_val, 0);
    check("rst_flit_data", flit_data, 0);
    check("rst_afull", fifo_afull, 0);
    check("rst_drop", drop_cnt, 0);

    // single type-5 frame, length 3 -> 8 flits; stray mac_done without a word
    ack_mode = 1;
    repeat (2) @(posedge clk);
    start_case();
    arm_val = 1;
    send_hdr(5, 3);
    t0 = cyc;
    for (int i = 1; i < 8; i++) begin
      send_word(i == 7, 1'b0);
      if (i == 3) gap(1'b1);
    end
    gap(1'b0);
    drain();
    check("t1_latency", val_cyc - t0, 2);
    check_tags("t1", 8, 64'h4002);
    check("t1_drop", drop_cnt, 0);
    check("t1_crc", crc_cnt, 0);
    check("t1_lenerr", lenerr_seen, 0);

    // two back-to-back type-0 frames with toggling ack
    ack_mode = 2;
    start_case();
    for (int f = 0; f < 2; f++) begin
      send_hdr(0, $urandom_range(0, 50));
      send_word(1'b0, 1'b0);
      send_word(1'b0, 1'b0);
      send_word(1'b1, 1'b0);
    end
    gap(1'b0);
    drain();
    check_tags("t2", 8, 64'h4242);
    check("t2_drop", drop_cnt, 0);
    check("t2_overflow", overflow, 0);

    // truncated frame (L=15, done on word 6) then a type-3 frame
    start_case();
    send_hdr(5, 10);
    for (int i = 2; i <= 6; i++) send_word(i == 6, 1'b0);
    send_hdr(3, 7);
    for (int i = 2; i <= 4; i++) send_word(i == 4, 1'b0);
    gap(1'b0);
    drain();
    check_tags("t3", 10, 64'h42402);
    check("t3_lenerr", lenerr_seen, 1);

    // over-long type-0 frame, done on word 7
    start_case();
    send_hdr(0, 0);
    for (int i = 2; i <= 7; i++) send_word(i == 7, 1'b0);
    gap(1'b0);
    drain();
    check_tags("t4", 4, 64'h42);
    check("t4_drop", drop_cnt, 3);
    check("t4_lenerr", lenerr_seen, 1);

    // ack held low, 20-word frame fills FIFO and output register
    ack_mode = 0;
    apply_reset();
    start_case();
    arm_afull = 1;
    send_hdr(5, 15);
    t0 = cyc;
    for (int i = 2; i <= 20; i++) send_word(i == 20, 1'b0);
    gap(1'b0);
    repeat (3) @(negedge clk);
    check("t5_afull_at_14", afull_cyc - t0, 15);
    check("t5_overflow", overflow, 1);
    check("t5_drop", drop_cnt, 3);
    drain();
    check_tags("t5", 17, 64'h2);
    check("t5_overflow_sticky", overflow, 1);

    // CRC error on a tail, then reset mid-frame
    apply_reset();
    ack_mode = 1;
    start_case();
    send_hdr(0, 0);
    send_word(1'b0, 1'b0);
    send_word(1'b0, 1'b0);
    send_word(1'b1, 1'b1);
    gap(1'b0);
    drain();
    check_tags("t6a", 4, 64'h42);
    check("t6_crc", crc_cnt, 1);
    ack_mode = 0;
    send_hdr(5, 4);
    send_word(1'b0, 1'b0);
    send_word(1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1; mac_valid = '0;
    @(posedge clk);
    @(negedge clk);
    check("t6_rst_flit_val", flit_val, 0);
    check("t6_rst_flit_data", flit_data, 0);
    check("t6_rst_afull", fifo_afull, 0);
    check("t6_rst_overflow", overflow, 0);
    check("t6_rst_len_err", len_err, 0);
    check("t6_rst_drop", drop_cnt, 0);
    check("t6_rst_crc", crc_cnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ack_mode = 1;
    start_case();
    send_hdr(0, 0);
    send_word(1'b0, 1'b0);
    send_word(1'b0, 1'b0);
    send_word(1'b1, 1'b0);
    gap(1'b0);
    drain();
    check_tags("t6b", 4, 64'h42);
    check("t6b_lenerr", lenerr_seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
